// File: rtl/psum_pack_pkg.sv
// Shared types and sizing helpers for the partial-sum vector packer.
package psum_pack_pkg;

  localparam int unsigned PSUM_LANES = 8;
  localparam int unsigned PSUM_WIDTH = 16;

  typedef enum logic [0:0] {
    FILL,
    PEND
  } state_e;

  // Width able to hold a lane count of 0..lanes.
  function automatic int unsigned lane_cnt_width(input int unsigned lanes);
    return $clog2(lanes) + 1;
  endfunction

  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/psum_lane_buffer.sv
// LANES x WIDTH lane register: indexed write that zeroes all higher lanes,
// optional whole-vector load, packed read-out.
module psum_lane_buffer
  import psum_pack_pkg::*;
#(
  parameter int unsigned LANES = PSUM_LANES,
  parameter int unsigned WIDTH = PSUM_WIDTH,
  localparam int unsigned IDXW = lane_idx_width(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDXW-1:0]        wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   ld_en,
  input  logic [LANES*WIDTH-1:0] ld_data,
  output logic [LANES*WIDTH-1:0] rd_data
);

  logic [LANES-1:0][WIDTH-1:0] lane_q;

  // Every write clears the lanes above it, so lane 0 of a new vector wipes
  // the previous vector and a closing lane leaves zero padding behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (ld_en) begin
      lane_q <= ld_data;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (IDXW'(i) == wr_idx) begin
          lane_q[i] <= wr_data;
        end else if (IDXW'(i) > wr_idx) begin
          lane_q[i] <= '0;
        end
      end
    end
  end

  assign rd_data = lane_q;

endmodule

// File: rtl/psum_vec_packer.sv
// Serial-to-parallel packer of signed partial sums into one lane vector.
// Define PSUM_PACK_DBUF_EN to build with a separate fill buffer (double buffering).
module psum_vec_packer
  import psum_pack_pkg::*;
#(
  parameter int unsigned LANES = PSUM_LANES,
  parameter int unsigned WIDTH = PSUM_WIDTH,
  localparam int unsigned IDXW = lane_idx_width(LANES),
  localparam int unsigned CNTW = lane_cnt_width(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic [LANES*WIDTH-1:0] vec_data,
  output logic [CNTW-1:0]        vec_lanes
);

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        lane_cnt_q, lane_cnt_d;
  logic                   vec_valid_q, vec_valid_d;
  logic [CNTW-1:0]        vec_lanes_q, vec_lanes_d;
  logic                   accept;
  logic                   close;
  logic                   load;
  logic [CNTW-1:0]        close_lanes;
  logic [LANES*WIDTH-1:0] fill_vec;

  assign accept      = in_valid && in_ready;
  assign close       = accept && (in_last || (lane_cnt_q == IDXW'(LANES - 1)));
  assign close_lanes = CNTW'(lane_cnt_q) + CNTW'(1);

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    if (close) begin
      lane_cnt_d = '0;
    end else if (accept) begin
      lane_cnt_d = lane_cnt_q + IDXW'(1);
    end
  end

`ifdef PSUM_PACK_DBUF_EN
  logic                   slot_free;
  logic                   ld_pend;
  logic [CNTW-1:0]        pend_lanes_q, pend_lanes_d;
  logic [LANES*WIDTH-1:0] close_vec;
  logic [LANES*WIDTH-1:0] ld_vec;

  assign slot_free = !vec_valid_q || vec_ready;
  assign in_ready  = (state_q == FILL);

  psum_lane_buffer #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_fill (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (lane_cnt_q),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_data (fill_vec)
  );

  // The closing lane is not in the fill buffer yet, so merge it in on the fly.
  always_comb begin
    close_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      if (IDXW'(i) < lane_cnt_q) begin
        close_vec[i*WIDTH +: WIDTH] = fill_vec[i*WIDTH +: WIDTH];
      end else if (IDXW'(i) == lane_cnt_q) begin
        close_vec[i*WIDTH +: WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    ld_pend      = 1'b0;
    vec_lanes_d  = vec_lanes_q;
    pend_lanes_d = pend_lanes_q;
    unique case (state_q)
      FILL: begin
        if (close) begin
          if (slot_free) begin
            load        = 1'b1;
            vec_lanes_d = close_lanes;
          end else begin
            state_d      = PEND;
            pend_lanes_d = close_lanes;
          end
        end
      end
      PEND: begin
        if (vec_ready) begin
          load        = 1'b1;
          ld_pend     = 1'b1;
          vec_lanes_d = pend_lanes_q;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign ld_vec = ld_pend ? fill_vec : close_vec;

  psum_lane_buffer #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (load),
    .ld_data (ld_vec),
    .rd_data (vec_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_lanes_q <= '0;
    end else begin
      pend_lanes_q <= pend_lanes_d;
    end
  end
`else
  // Fill buffer doubles as the output register; it is frozen while held.
  assign in_ready = (state_q == FILL) && !vec_valid_q;
  assign load     = close;
  assign vec_data = fill_vec;

  psum_lane_buffer #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_fill (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (lane_cnt_q),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_data (fill_vec)
  );

  always_comb begin
    state_d     = FILL;
    vec_lanes_d = vec_lanes_q;
    if (close) begin
      vec_lanes_d = close_lanes;
    end
  end
`endif

  always_comb begin
    vec_valid_d = vec_valid_q;
    if (load) begin
      vec_valid_d = 1'b1;
    end else if (vec_ready) begin
      vec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      lane_cnt_q  <= '0;
      vec_valid_q <= 1'b0;
      vec_lanes_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      vec_valid_q <= vec_valid_d;
      vec_lanes_q <= vec_lanes_d;
    end
  end

  assign vec_valid = vec_valid_q;
  assign vec_lanes = vec_lanes_q;

endmodule

// File: tb/tb_psum_vec_packer.sv
// Bench for psum_vec_packer: directed timing cases plus a randomized stream
// scored against a queue model of packed vectors.
module tb_psum_vec_packer;

  localparam int unsigned LANES = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned VW    = LANES * W;
  localparam int unsigned CNTW  = $clog2(LANES) + 1;
`ifdef PSUM_PACK_DBUF_EN
  localparam int EXP_PERIOD = LANES;
`else
  localparam int EXP_PERIOD = LANES + 1;
`endif

  typedef struct packed {
    logic [VW-1:0]   data;
    logic [CNTW-1:0] lanes;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic            vec_valid;
  logic            vec_ready;
  logic [VW-1:0]   vec_data;
  logic [CNTW-1:0] vec_lanes;

  psum_vec_packer #(
    .LANES (LANES),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_lanes (vec_lanes)
  );

  always #5 clk = ~clk;

  int            num_checks = 0;
  int            num_fail   = 0;
  vec_t          exp_q[$];
  int            hs_q[$];
  logic [VW-1:0] cur_vec    = '0;
  int            cur_n      = 0;
  int            cyc        = 0;
  logic          hold_prev  = 1'b0;
  logic [VW-1:0] prev_data;
  logic [CNTW-1:0] prev_lanes;
  logic          rnd_done   = 1'b0;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: handshakes are observed mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    vec_t e;
    cyc++;
    if (!rst_n) begin
      cur_n     = 0;
      hold_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (hold_prev) begin
        check_eq("hold_valid", VW'(vec_valid), VW'(1));
        check_eq("hold_data", vec_data, prev_data);
        check_eq("hold_lanes", VW'(vec_lanes), VW'(prev_lanes));
      end
      if (vec_valid && vec_ready) begin
        hs_q.push_back(cyc);
        check_eq("sb_nonempty", VW'(exp_q.size() != 0), VW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_data", vec_data, e.data);
          check_eq("sb_lanes", VW'(vec_lanes), VW'(e.lanes));
        end
      end
      if (in_valid && in_ready) begin
        if (cur_n == 0) cur_vec = '0;
        cur_vec[cur_n*W +: W] = in_data;
        cur_n++;
        if (in_last || cur_n == LANES) begin
          exp_q.push_back('{data: cur_vec, lanes: CNTW'(cur_n)});
          cur_n = 0;
        end
      end
      hold_prev  = vec_valid && !vec_ready;
      prev_data  = vec_data;
      prev_lanes = vec_lanes;
    end
  end

  task automatic send_lane(input logic [W-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("in_ready_timeout", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [VW-1:0] exp_vec;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    vec_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_vec_valid", VW'(vec_valid), VW'(0));
    check_eq("rst_vec_data", vec_data, VW'(0));
    check_eq("rst_vec_lanes", VW'(vec_lanes), VW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_in_ready", VW'(in_ready), VW'(1));

    // Full vector, lanes 1..8
    vec_ready = 1'b1;
    for (int i = 0; i < LANES - 1; i++) send_lane(W'(i + 1), 1'b0);
    check_eq("full_early_valid", VW'(vec_valid), VW'(0));
    send_lane(W'(LANES), 1'b0);
    exp_vec = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    check_eq("full_valid", VW'(vec_valid), VW'(1));
    check_eq("full_data", vec_data, exp_vec);
    check_eq("full_lanes", VW'(vec_lanes), VW'(8));

    // Short vector with extreme values
    send_lane(16'hFFFF, 1'b0);
    send_lane(16'h7FFF, 1'b0);
    send_lane(16'h8000, 1'b1);
    exp_vec = 128'h0000_0000_0000_0000_0000_8000_7FFF_FFFF;
    check_eq("short_valid", VW'(vec_valid), VW'(1));
    check_eq("short_data", vec_data, exp_vec);
    check_eq("short_lanes", VW'(vec_lanes), VW'(3));
    repeat (2) @(negedge clk);

    // Backpressure: two full vectors against a stalled consumer
    @(posedge clk);
    #1 vec_ready = 1'b0;
    exp_vec = '0;
    for (int i = 0; i < LANES; i++) exp_vec[i*W +: W] = W'(32'h1000 + i);
    fork
      begin
        for (int i = 0; i < 2 * LANES; i++) send_lane(W'(32'h1000 + i), 1'b0);
      end
      begin
        repeat (20) @(negedge clk);
        check_eq("bp_in_ready_held", VW'(in_ready), VW'(0));
        check_eq("bp_valid_held", VW'(vec_valid), VW'(1));
        check_eq("bp_data_first", vec_data, exp_vec);
        check_eq("bp_lanes_first", VW'(vec_lanes), VW'(8));
        @(posedge clk);
        #1 vec_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_in_ready_at_hs", VW'(in_ready), VW'(0));
        @(negedge clk);
        check_eq("bp_in_ready_after_hs", VW'(in_ready), VW'(1));
      end
    join
    repeat (4) @(negedge clk);

    // Throughput: four full vectors, consumer always ready
    hs_q.delete();
    for (int i = 0; i < 4 * LANES; i++) send_lane(W'($urandom), 1'b0);
    repeat (4) @(negedge clk);
    check_eq("tp_count", VW'(hs_q.size()), VW'(4));
    for (int i = 1; i < hs_q.size(); i++) begin
      check_eq("tp_period", VW'(hs_q[i] - hs_q[i-1]), VW'(EXP_PERIOD));
    end

    // Reset in the middle of a fill
    for (int i = 0; i < 4; i++) send_lane(W'(32'hDEA0 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", VW'(vec_valid), VW'(0));
    check_eq("mid_rst_data", vec_data, VW'(0));
    check_eq("mid_rst_lanes", VW'(vec_lanes), VW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("mid_rst_in_ready", VW'(in_ready), VW'(1));
    exp_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      exp_vec[i*W +: W] = W'(32'h2000 + i);
      send_lane(W'(32'h2000 + i), 1'b0);
    end
    check_eq("post_rst_data", vec_data, exp_vec);
    check_eq("post_rst_lanes", VW'(vec_lanes), VW'(8));
    repeat (2) @(negedge clk);

    // Randomized stream with random idles and consumer stalls
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_lane(W'($urandom), $urandom_range(4) == 0);
        end
        send_lane(W'($urandom), 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 vec_ready = 1'($urandom_range(1));
        end
      end
    join
    vec_ready = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rnd_drained", VW'(exp_q.size()), VW'(0));
    check_eq("rnd_idle_valid", VW'(vec_valid), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
